// File: rtl/rcu_clk_seq.sv
// rtl/rcu_clk_seq.sv - reset/clock-unit sequencer: PLL reconfiguration and bypass switching
// Glitch-safe clock reselection with lock qualification, timeout and lock-loss fallback.
module rcu_clk_seq #(
  parameter int SW_WAIT     = 4,
  parameter int OFF_CYC     = 4,
  parameter int LOCK_STABLE = 8,
  parameter int LOCK_TO     = 1024
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [2:0] req_cfg_i,
  input  logic       req_bypass_i,
  input  logic       pll_lock_i,
  output logic       pll_en_o,
  output logic [2:0] clk_cfg_o,
  output logic       clk_sel_o,
  output logic       dom_rst_n_o,
  output logic       done_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BYP_SW    = 3'd1,
    PLL_OFF   = 3'd2,
    WAIT_LOCK = 3'd3,
    SWITCH    = 3'd4,
    RELEASE   = 3'd5,
    ERROR     = 3'd6
  } state_t;

  localparam int PH_MAX = (SW_WAIT > OFF_CYC) ? SW_WAIT : OFF_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int ST_W   = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int TO_W   = $clog2(LOCK_TO);

  localparam logic [PH_W-1:0] SW_LAST  = PH_W'(SW_WAIT - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYC - 1);
  localparam logic [ST_W-1:0] ST_LAST  = ST_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(LOCK_TO - 1);

  state_t          state, state_nxt;
  logic [PH_W-1:0] ph_cnt, ph_nxt;
  logic [ST_W-1:0] stab_cnt, stab_nxt;
  logic [TO_W-1:0] to_cnt, to_nxt;
  logic [2:0]      cfg_q, cfg_nxt;
  logic            byp_q, byp_nxt;
  logic [1:0]      lock_sync;
  logic            lock_s;
  logic            accept;
  logic            loss;

  logic            pll_en_nxt, sel_nxt, dom_nxt, done_nxt, err_nxt, ready_nxt;
  logic [2:0]      cfg_out_nxt;

  assign lock_s  = lock_sync[1];
  assign accept  = req_valid_i & req_ready_o;
  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock_i};
    end
  end

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph_cnt;
    stab_nxt  = stab_cnt;
    to_nxt    = to_cnt;
    cfg_nxt   = cfg_q;
    byp_nxt   = byp_q;
    loss      = 1'b0;

    case (state)
      IDLE, ERROR: begin
        // An accepted request outranks lock loss: the new sequence leaves the PLL clock anyway.
        if (accept) begin
          state_nxt = BYP_SW;
          cfg_nxt   = req_cfg_i;
          byp_nxt   = req_bypass_i;
        end else if (state == IDLE && clk_sel_o && !lock_s) begin
          state_nxt = ERROR;
          loss      = 1'b1;
        end
      end
      BYP_SW: begin
        if (ph_cnt == SW_LAST) state_nxt = PLL_OFF;
        else                   ph_nxt    = ph_cnt + 1'b1;
      end
      PLL_OFF: begin
        if (ph_cnt == OFF_LAST) state_nxt = byp_q ? RELEASE : WAIT_LOCK;
        else                    ph_nxt    = ph_cnt + 1'b1;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          if (stab_cnt == ST_LAST) state_nxt = SWITCH;
          else                     stab_nxt  = stab_cnt + 1'b1;
        end else begin
          stab_nxt = '0;
        end
        // Stability is evaluated first so it wins a same-cycle tie with the timeout.
        if (state_nxt == WAIT_LOCK) begin
          if (to_cnt == TO_LAST) state_nxt = ERROR;
          else                   to_nxt    = to_cnt + 1'b1;
        end
      end
      SWITCH: begin
        if (ph_cnt == SW_LAST) state_nxt = RELEASE;
        else                   ph_nxt    = ph_cnt + 1'b1;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) begin
      ph_nxt   = '0;
      stab_nxt = '0;
      to_nxt   = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they align with state_o.
  always_comb begin
    pll_en_nxt  = pll_en_o;
    cfg_out_nxt = clk_cfg_o;
    sel_nxt     = clk_sel_o;
    dom_nxt     = dom_rst_n_o;
    done_nxt    = 1'b0;
    err_nxt     = err_o;
    ready_nxt   = (state_nxt == IDLE) || (state_nxt == ERROR);

    case (state_nxt)
      IDLE: dom_nxt = 1'b1;
      BYP_SW: begin
        sel_nxt = 1'b0;
        dom_nxt = 1'b0;
        err_nxt = 1'b0;
      end
      PLL_OFF: begin
        pll_en_nxt  = 1'b0;
        cfg_out_nxt = cfg_q;
        sel_nxt     = 1'b0;
        dom_nxt     = 1'b0;
      end
      WAIT_LOCK: pll_en_nxt = 1'b1;
      SWITCH:    sel_nxt    = 1'b1;
      RELEASE: begin
        dom_nxt  = 1'b1;
        done_nxt = 1'b1;
      end
      ERROR: begin
        pll_en_nxt = 1'b0;
        sel_nxt    = 1'b0;
        err_nxt    = 1'b1;
        // Lock loss pulses the domain reset low for one cycle.
        dom_nxt    = ~loss;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      ph_cnt      <= '0;
      stab_cnt    <= '0;
      to_cnt      <= '0;
      cfg_q       <= 3'd0;
      byp_q       <= 1'b0;
      pll_en_o    <= 1'b0;
      clk_cfg_o   <= 3'd0;
      clk_sel_o   <= 1'b0;
      dom_rst_n_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      req_ready_o <= 1'b1;
    end else begin
      state       <= state_nxt;
      ph_cnt      <= ph_nxt;
      stab_cnt    <= stab_nxt;
      to_cnt      <= to_nxt;
      cfg_q       <= cfg_nxt;
      byp_q       <= byp_nxt;
      pll_en_o    <= pll_en_nxt;
      clk_cfg_o   <= cfg_out_nxt;
      clk_sel_o   <= sel_nxt;
      dom_rst_n_o <= dom_nxt;
      done_o      <= done_nxt;
      err_o       <= err_nxt;
      req_ready_o <= ready_nxt;
    end
  end

endmodule
